ps2_button_mapper: RTL and testbench
====================================

# ps2_button_mapper

Parametrised PS/2 keyboard-to-button mapper for arcade cores: converts toggle-strobed key events from the HPS keyboard channel into `NUM_BUTTONS` held-button levels via a runtime-programmable keymap table. It sits between `hps_io` and the game core, alongside the joystick OR logic.

It adds three behaviours to a fixed keymap:

- Several keys can map to one button without releasing each other.
- Each button has optional autofire.
- A global release-all clear.

## Interface

Parameters:

- `NUM_BUTTONS`, 16: button outputs; 2..32.
- `NUM_ENTRIES`, 32: keymap table entries; power of two, 4..64.
- `AUTOFIRE_PERIOD`, 1_000_000: `clk_sys` cycles per autofire phase. Minimum 2.

Ports:

- `clk_sys`  in  1  system clock. One clock domain; reset is synchronous and active-low.
- `reset_n`  in  1  synchronous, active-low reset.
- `ps2_key`  in  11  keyboard event word.
  - [10] toggles once per event.
  - [9] pressed (1 = make).
  - [8] extended (E0 prefix).
  - [7:0] scan code.
- `map_we`  in  1  keymap write strobe.
- `map_addr`  in  $clog2(NUM_ENTRIES)  entry index to write.
- `map_data`  in  10+$clog2(NUM_BUTTONS)  entry fields {valid, ext, code[7:0], btn}.
- `clear`  in  1  release all keys and abort scan.
- `autofire_en`  in  NUM_BUTTONS  per-button autofire enable.
- `buttons`  out  NUM_BUTTONS  button levels; 1 = pressed.
- `busy`  out  1  table scan in progress.
- `key_hit`  out  1  one-cycle pulse: the last scanned event matched ≥1 valid entry.
- `overrun`  out  1  one-cycle pulse: a pending event was overwritten.

## Operation

- Reset (`reset_n` low at an edge) clears:
  - all entry `valid` bits and all `key_state` bits;
  - the pending buffer and the autofire counter;
  - all outputs (`buttons`, `busy`, `key_hit`, `overrun` = 0).
- During reset, `last_tog` loads `ps2_key[10]`, so no spurious event occurs after reset.
- Event detect: `ps2_key[10] != last_tog` → latch {pressed, ext, code} and set `last_tog`.
  - If the FSM is IDLE, start the scan.
  - Otherwise store the event in the one-deep pending buffer.
  - If pending is already full, the new event overwrites it and `overrun` pulses.
- FSM states: IDLE and SCAN.
  - IDLE→SCAN on a detected or pending event; the pending buffer is consumed on that transition. `idx` = 0.
  - In SCAN, one entry is compared per cycle. If `valid && ext==ev.ext && code==ev.code`, then `key_state[idx] <= ev.pressed`.
  - Every matching entry is updated, so duplicate keys are legal.
  - After `idx == NUM_ENTRIES-1`: `key_hit` pulses if any entry matched. Go to SCAN idx 0 if pending, else IDLE.
- Button hold: `held[b]` = OR over entries e of (`valid[e] && btn[e]==b && key_state[e]`).
  - Releasing one of two keys mapped to the same button keeps it held.
  - Entries with `btn >= NUM_BUTTONS` are ignored.
- Output: `buttons[b] <= held[b] & (~autofire_en[b] | af_phase)`, registered.
- Autofire generator:
  - A counter runs 0..AUTOFIRE_PERIOD-1; `af_phase` toggles at wrap.
  - While no autofire-enabled button is held, counter = 0 and `af_phase` = 1, so the first shot is immediate.
- Map write: writes the entry and clears its `key_state`, at any time including mid-scan.
  - If a write and a scan update hit the same entry in the same cycle, the write wins.
- `clear`: zeroes all `key_state` bits and the pending buffer, and forces IDLE.
  - A toggle arriving in the same cycle updates `last_tog` but is discarded.
  - `clear` has priority over event detect and scan. Reset has priority over everything.

## Timing

- Detection edge D. Entry i is compared in the cycle after edge D+i and updates `key_state` at edge D+i+1.
- `buttons` follows `key_state` by one edge. Worst-case latency is NUM_ENTRIES+2 cycles.
- `busy` is high from edge D through the final scan edge D+NUM_ENTRIES (longer if pending).
- `key_hit` is high for the cycle following edge D+NUM_ENTRIES.
- A map write at edge W affects `buttons` at edge W+1.
- `autofire_en` changes reach `buttons` one edge later.

## Structure

- `ps2_map_pkg` contains:
  - the `map_entry_t` struct {valid, ext, code, btn};
  - the PS2 bit-position localparams (TOG=10, PRS=9, EXT=8);
  - the FSM state enum.
- Sub-module `autofire_gen` contains the counter and phase logic. Parameter: `AUTOFIRE_PERIOD`. Ports: `clk_sys`, `reset_n`, `active`, `phase`.
- The table is register-based, not RAM, because the OR-reduction reads every entry each cycle.

## Test plan

- Dual-key hold:
  - Stimulus: program entry 0 = {1,1,0x6B,btn 2} and entry 1 = {1,1,0x74,btn 2}. Press E0-6B, press E0-74, release E0-6B.
  - Required: `buttons[2]` stays 1. Release E0-74 → `buttons[2]`=0 within 34 cycles.
- Scan latency, with NUM_ENTRIES=32:
  - Stimulus: entry 31 = {1,0,0x29,btn 0}; toggle with press 0x29.
  - Required: `busy` is high for 32 cycles; `buttons[0]` rises at D+33; `key_hit` pulses once.
- Pending and overrun:
  - Three toggles 1 cycle apart during a scan → `overrun` pulses once; exactly two scans run; the final state reflects events 1 and 3.
- Autofire, with AUTOFIRE_PERIOD=4:
  - `autofire_en[0]`=1, key held → `buttons[0]` pattern 1111 0000 repeating, starting immediately.
- Clear and rewrite:
  - Hold btn 3, assert `clear` mid-scan → `buttons`=0 next edge and `busy`=0.
  - Rewriting a held entry drops its button at W+1.
- Reset:
  - Toggle `ps2_key[10]` while `reset_n`=0, then deassert → no scan, all outputs 0, all entries invalid.

Source files
------------

// File: rtl/ps2_map_pkg.sv
// Shared types and constants for the PS/2 keyboard-to-button mapper.
package ps2_map_pkg;

  localparam int unsigned TOG    = 10;
  localparam int unsigned PRS    = 9;
  localparam int unsigned EXT    = 8;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned BTN_W  = 5;

  typedef struct packed {
    logic              valid;
    logic              ext;
    logic [CODE_W-1:0] code;
    logic [BTN_W-1:0]  btn;
  } map_entry_t;

  typedef struct packed {
    logic              pressed;
    logic              ext;
    logic [CODE_W-1:0] code;
  } ps2_event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/autofire_gen.sv
// Autofire phase generator: phase toggles every AUTOFIRE_PERIOD cycles while active,
// parked high when idle so the first shot fires at once.
module autofire_gen #(
  parameter int unsigned AUTOFIRE_PERIOD = 1_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic active,
  output logic phase
);

  localparam int unsigned CW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n || !active) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (cnt_q == CW'(AUTOFIRE_PERIOD - 1)) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_button_mapper.sv
// PS/2 key events to held button levels through a programmable keymap, with
// per-button autofire, one-deep event buffering and a global clear.
module ps2_button_mapper
  import ps2_map_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 16,
  parameter int unsigned NUM_ENTRIES     = 32,
  parameter int unsigned AUTOFIRE_PERIOD = 1_000_000
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic [10:0]                      ps2_key,
  input  logic                             map_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   map_addr,
  input  logic [10+$clog2(NUM_BUTTONS)-1:0] map_data,
  input  logic                             clear,
  input  logic [NUM_BUTTONS-1:0]           autofire_en,
  output logic [NUM_BUTTONS-1:0]           buttons,
  output logic                             busy,
  output logic                             key_hit,
  output logic                             overrun
);

  localparam int unsigned AW = $clog2(NUM_ENTRIES);
  localparam int unsigned BW = $clog2(NUM_BUTTONS);
  localparam int unsigned DW = 10 + BW;

  map_entry_t             table_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] key_state_q;

  state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  ps2_event_t ev_q, ev_d;
  ps2_event_t pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       hit_q, hit_d;
  logic       busy_d, key_hit_d, overrun_d;

  logic       last_tog;
  logic       new_ev;
  ps2_event_t new_word;
  map_entry_t wr_entry;
  map_entry_t cur;
  logic       scan_match;
  logic       last_entry;

  logic [NUM_BUTTONS-1:0] held;
  logic                   af_active;
  logic                   af_phase;

  // Edge detector on the toggle bit; tracks the input even in reset.
  always_ff @(posedge clk_sys) begin
    last_tog <= ps2_key[TOG];
  end

  assign new_ev   = (ps2_key[TOG] != last_tog);
  assign new_word = {ps2_key[PRS], ps2_key[EXT], ps2_key[CODE_W-1:0]};
  assign wr_entry = {map_data[DW-1], map_data[DW-2], map_data[DW-3 -: CODE_W],
                     BTN_W'(map_data[BW-1:0])};

  assign cur        = table_q[idx_q];
  assign scan_match = (state_q == ST_SCAN) && cur.valid &&
                      (cur.ext == ev_q.ext) && (cur.code == ev_q.code);
  assign last_entry = (state_q == ST_SCAN) && (idx_q == AW'(NUM_ENTRIES - 1));

  // Keymap table and per-entry key state; a map write overrides a same-cycle scan hit.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        table_q[e] <= '0;
      end
      key_state_q <= '0;
    end else begin
      if (clear) begin
        key_state_q <= '0;
      end else if (scan_match) begin
        key_state_q[idx_q] <= ev_q.pressed;
      end
      if (map_we) begin
        table_q[map_addr]     <= wr_entry;
        key_state_q[map_addr] <= 1'b0;
      end
    end
  end

  // Scan controller state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ev_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      hit_q      <= 1'b0;
      busy       <= 1'b0;
      key_hit    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ev_q       <= ev_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hit_q      <= hit_d;
      busy       <= busy_d;
      key_hit    <= key_hit_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state: start a scan from pending first, else from a fresh event.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ev_d       = ev_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hit_d      = hit_q;
    busy_d     = 1'b0;
    key_hit_d  = 1'b0;
    overrun_d  = 1'b0;

    if (clear) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      pend_vld_d = 1'b0;
      hit_d      = 1'b0;
    end else begin
      if (state_q == ST_SCAN) begin
        hit_d = hit_q | scan_match;
        idx_d = idx_q + AW'(1);
      end
      if (last_entry) begin
        key_hit_d = hit_q | scan_match;
      end

      if (state_q == ST_IDLE || last_entry) begin
        idx_d = '0;
        hit_d = 1'b0;
        if (pend_vld_q) begin
          state_d    = ST_SCAN;
          ev_d       = pend_q;
          pend_vld_d = new_ev;
          if (new_ev) begin
            pend_d = new_word;
          end
        end else if (new_ev) begin
          state_d = ST_SCAN;
          ev_d    = new_word;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (new_ev) begin
        pend_d     = new_word;
        pend_vld_d = 1'b1;
        overrun_d  = pend_vld_q;
      end

      busy_d = (state_d == ST_SCAN);
    end
  end

  // A button is held while any valid entry mapped to it has its key down.
  always_comb begin
    held = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (table_q[e].valid && key_state_q[e] && (table_q[e].btn == BTN_W'(b))) begin
          held[b] = 1'b1;
        end
      end
    end
  end

  assign af_active = |(held & autofire_en);

  autofire_gen #(
    .AUTOFIRE_PERIOD(AUTOFIRE_PERIOD)
  ) u_autofire (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .active (af_active),
    .phase  (af_phase)
  );

  // Clear drops the buttons on the same edge instead of waiting for key_state.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clear) begin
      buttons <= '0;
    end else begin
      buttons <= held & (~autofire_en | {NUM_BUTTONS{af_phase}});
    end
  end

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Self-checking bench for ps2_button_mapper: keymap vectors with a scoreboard plus
// latency, pending/overrun, autofire, clear/rewrite and reset sequences.
module tb_ps2_button_mapper;

  localparam int unsigned NB  = 16;
  localparam int unsigned NE  = 32;
  localparam int unsigned AFP = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic          map_we;
  logic [4:0]    map_addr;
  logic [13:0]   map_data;
  logic          clear;
  logic [NB-1:0] autofire_en;
  logic [NB-1:0] buttons;
  logic          busy;
  logic          key_hit;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  int mon_busy = 0;
  int mon_hit  = 0;
  int mon_ovr  = 0;

  typedef struct {
    logic        pressed;
    logic        ext;
    logic [7:0]  code;
    logic [15:0] exp_btn;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    logic [15:0] btn;
    logic        hit;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  ps2_button_mapper #(
    .NUM_BUTTONS    (NB),
    .NUM_ENTRIES    (NE),
    .AUTOFIRE_PERIOD(AFP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .map_we     (map_we),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .clear      (clear),
    .autofire_en(autofire_en),
    .buttons    (buttons),
    .busy       (busy),
    .key_hit    (key_hit),
    .overrun    (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (busy)    mon_busy++;
    if (key_hit) mon_hit++;
    if (overrun) mon_ovr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
    tick();
  endtask

  task automatic map_wr(input logic [4:0] a, input logic v, input logic e,
                        input logic [7:0] c, input logic [3:0] b);
    map_we   = 1'b1;
    map_addr = a;
    map_data = {v, e, c, b};
    tick();
    map_we   = 1'b0;
  endtask

  task automatic wait_scan(output logic hit_seen);
    int cyc;
    cyc      = 0;
    hit_seen = 1'b0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
      if (key_hit) hit_seen = 1'b1;
    end
    chk("scan_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    logic hit;
    exp_t e;
    logic vals[50];
    int   busy_ones, first_low, hit_cnt, hit_idx, rise_idx;
    int   b0, h0, o0, cyc;
    logic busy_seen;

    reset_n     = 1'b0;
    ps2_key     = '0;
    map_we      = 1'b0;
    map_addr    = '0;
    map_data    = '0;
    clear       = 1'b0;
    autofire_en = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk("rst_buttons", 32'(buttons), 32'(0));
    chk("rst_busy",    32'(busy),    32'(0));
    chk("rst_key_hit", 32'(key_hit), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));

    map_wr(5'd0, 1'b1, 1'b1, 8'h6B, 4'd2);
    map_wr(5'd1, 1'b1, 1'b1, 8'h74, 4'd2);
    map_wr(5'd2, 1'b1, 1'b0, 8'h1C, 4'd5);
    map_wr(5'd3, 1'b1, 1'b0, 8'h1C, 4'd7);
    map_wr(5'd4, 1'b0, 1'b0, 8'h32, 4'd9);

    vecs[0] = '{1'b1, 1'b1, 8'h6B, 16'h0004, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h74, 16'h0004, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h6B, 16'h0004, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h74, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h1C, 16'h00A0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h6B, 16'h00A0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h32, 16'h00A0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h1C, 16'h0000, 1'b1};

    for (int i = 0; i < 8; i++) begin
      sb.push_back('{vecs[i].exp_btn, vecs[i].exp_hit});
      send(vecs[i].pressed, vecs[i].ext, vecs[i].code);
      wait_scan(hit);
      tick();
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_buttons", i), 32'(buttons), 32'(e.btn));
      chk($sformatf("vec%0d_key_hit", i), 32'(hit), 32'(e.hit));
    end

    // Worst-case latency through the last table entry.
    map_wr(5'd31, 1'b1, 1'b0, 8'h29, 4'd0);
    send(1'b1, 1'b0, 8'h29);
    busy_ones = 0; first_low = -1; hit_cnt = 0; hit_idx = -1; rise_idx = -1;
    for (int n = 0; n < 41; n++) begin
      if (busy) busy_ones++;
      else if (first_low < 0) first_low = n;
      if (key_hit) begin hit_cnt++; hit_idx = n; end
      if (buttons[0] && rise_idx < 0) rise_idx = n;
      tick();
    end
    chk("lat_busy_cycles", 32'(busy_ones), 32'(32));
    chk("lat_busy_drop",   32'(first_low), 32'(32));
    chk("lat_hit_count",   32'(hit_cnt),   32'(1));
    chk("lat_hit_index",   32'(hit_idx),   32'(32));
    chk("lat_btn_rise",    32'(rise_idx),  32'(33));

    // Autofire pattern, first phase immediate.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("af_cleared", 32'(buttons), 32'(0));
    autofire_en = 16'h0001;
    send(1'b1, 1'b0, 8'h29);
    for (int n = 0; n < 50; n++) begin
      vals[n] = buttons[0];
      tick();
    end
    rise_idx = -1;
    for (int n = 0; n < 50; n++) if (vals[n] && rise_idx < 0) rise_idx = n;
    chk("af_first_shot", 32'(rise_idx), 32'(33));
    for (int k = 0; k < 16; k++)
      chk($sformatf("af_pattern%0d", k), 32'(vals[33+k]), 32'((k % 8) < 4));
    send(1'b0, 1'b0, 8'h29);
    wait_scan(hit);
    autofire_en = '0;
    tick();
    tick();
    chk("af_release", 32'(buttons), 32'(0));

    // Pending buffer and overrun.
    map_wr(5'd8,  1'b1, 1'b0, 8'h15, 4'd10);
    map_wr(5'd9,  1'b1, 1'b0, 8'h1D, 4'd11);
    map_wr(5'd10, 1'b1, 1'b0, 8'h24, 4'd12);
    b0 = mon_busy; h0 = mon_hit; o0 = mon_ovr;
    send(1'b1, 1'b0, 8'h15);
    send(1'b1, 1'b0, 8'h1D);
    send(1'b1, 1'b0, 8'h24);
    cyc = 0;
    while (busy && cyc < 150) begin tick(); cyc++; end
    chk("pend_timeout", 32'(busy), 32'(0));
    tick();
    tick();
    chk("pend_overrun", 32'(mon_ovr - o0),  32'(1));
    chk("pend_scans",   32'(mon_hit - h0),  32'(2));
    chk("pend_busy",    32'(mon_busy - b0), 32'(64));
    chk("pend_buttons", 32'(buttons & 16'h1C00), 32'(16'h1400));

    // Clear mid-scan.
    map_wr(5'd13, 1'b1, 1'b0, 8'h2B, 4'd3);
    send(1'b1, 1'b0, 8'h2B);
    wait_scan(hit);
    tick();
    tick();
    chk("clr_held", 32'(buttons[3]), 32'(1));
    send(1'b1, 1'b0, 8'h99);
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_buttons", 32'(buttons), 32'(0));
    chk("clr_busy",    32'(busy),    32'(0));
    tick();
    chk("clr_stays", 32'(buttons), 32'(0));

    // Rewriting a held entry drops its button one edge after the write.
    send(1'b1, 1'b0, 8'h2B);
    wait_scan(hit);
    tick();
    tick();
    chk("rw_held", 32'(buttons[3]), 32'(1));
    map_we   = 1'b1;
    map_addr = 5'd13;
    map_data = {1'b1, 1'b0, 8'h2B, 4'd3};
    tick();
    map_we   = 1'b0;
    chk("rw_edge_w",  32'(buttons[3]), 32'(1));
    tick();
    chk("rw_edge_w1", 32'(buttons[3]), 32'(0));

    // Reset with a toggle during reset.
    send(1'b1, 1'b1, 8'h6B);
    wait_scan(hit);
    tick();
    tick();
    chk("prerst_held", 32'(buttons[2]), 32'(1));
    reset_n = 1'b0;
    tick();
    ps2_key[10] = ~ps2_key[10];
    tick();
    tick();
    reset_n = 1'b1;
    busy_seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (busy) busy_seen = 1'b1;
    end
    chk("rst2_no_scan", 32'(busy_seen), 32'(0));
    chk("rst2_buttons", 32'(buttons),   32'(0));
    chk("rst2_key_hit", 32'(key_hit),   32'(0));
    chk("rst2_overrun", 32'(overrun),   32'(0));
    send(1'b1, 1'b1, 8'h6B);
    wait_scan(hit);
    tick();
    tick();
    chk("rst2_invalid_hit", 32'(hit),     32'(0));
    chk("rst2_invalid_btn", 32'(buttons), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
